dsp_ctrl_decoder: RTL and testbench
===================================

# dsp_ctrl_decoder

Control-word front end for the DSP slice datapath. It registers OPMODE, ALUMODE and CARRYINSEL under their clock enables and splits OPMODE into the X, Y and Z multiplexer selects. The 3-bit Z select drives the 8:1 Z multiplexer directly. It also checks each accepted control word against the slice's legality rules and keeps a saturating count of illegal words for debug.

## Interface
Parameters:
- OPMODEREG, 1: 1 = OPMODE/CARRYINSEL registered; 0 = combinational pass-through
- ALUMODEREG, 1: 1 = ALUMODE registered; 0 = pass-through
- MREG, 1: multiplier register present; used only for legality checking

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RSTCTRL  in  1  synchronous, active-high reset for every register in the block
- CECTRL  in  1  clock enable for OPMODE/CARRYINSEL registers
- CEALUMODE  in  1  clock enable for ALUMODE register
- OPMODE  in  7  control word: [1:0] X, [3:2] Y, [6:4] Z
- ALUMODE  in  4  ALU function
- CARRYINSEL  in  3  carry-in source
- x_sel  out  2  X mux select
- y_sel  out  2  Y mux select
- z_sel  out  3  Z mux select (8:1)
- alumode_q  out  4  effective ALUMODE
- carryin_sel  out  3  effective CARRYINSEL
- opmode_invalid  out  1  current effective word is illegal
- invalid_cnt  out  8  saturating count of accepted illegal words

## Operation
- Effective word: registered value when the REG parameter is 1; live input when it is 0.
- Select split: x_sel = word[1:0], y_sel = word[3:2], z_sel = word[6:4].
- Illegal words are still forwarded unchanged. Legality is only flagged, never corrected.
- opmode_invalid = 1 if any of the following holds for the effective OPMODE/CARRYINSEL:
  - (x_sel==2'b01) XOR (y_sel==2'b01), i.e. the two M halves are not selected together
  - z_sel==3'b111 (reserved)
  - carryin_sel==3'b110 with MREG==0
  - carryin_sel==3'b111
- Accepted word:
  - OPMODEREG=1: any cycle with CECTRL=1 and RSTCTRL=0
  - OPMODEREG=0: every cycle with RSTCTRL=0
- invalid_cnt increments by 1 on each accepted word that is illegal. With OPMODEREG=1 the check uses the incoming D-side word.
- invalid_cnt saturates at 8'hFF and does not wrap. It is cleared only by RSTCTRL.
- RSTCTRL has priority over both CE inputs. It clears all registers and the counter.

## Timing
- Reset values: x_sel=0, y_sel=0, z_sel=0, alumode_q=0, carryin_sel=0, opmode_invalid=0, invalid_cnt=0. OPMODE=0 is a legal word.
- Latency with REG=1: input to output is 1 cycle when CE=1. With CE=0 the outputs hold indefinitely.
- Latency with REG=0: outputs are combinational from the inputs, 0 cycles.
- opmode_invalid always has the same latency as the selects it describes.
- invalid_cnt updates one cycle after the accepted illegal word in both modes.
- Simultaneous RSTCTRL=1 and CECTRL=1 with an illegal word: registers and counter clear; the word is neither loaded nor counted.
- Reset mid-operation: all outputs take reset values on the next edge; normal operation resumes the cycle after RSTCTRL drops.
- Counter at 8'hFF with a further illegal accepted word: stays at 8'hFF.
- CECTRL and CEALUMODE are independent: ALUMODE can update while OPMODE holds, and the reverse.

## Structure
- Package dsp_ctrl_pkg holds:
  - OPMODE field slice positions
  - X/Y/Z select encoding constants (X_ZERO, X_M, X_P, X_AB; Y_ZERO, Y_M, Y_ALL1, Y_C; Z_ZERO, Z_PCIN, Z_P, Z_C, Z_PMACC, Z_PCIN17, Z_P17, Z_RSVD)
  - CARRYINSEL encoding constants
- Sub-module ctrl_reg (WIDTH, REG parameters): optional register with CE and synchronous reset, plus output mux. Instantiated three times: OPMODE, ALUMODE, CARRYINSEL.
- The legality function and the saturating counter live in the top level.

## Test plan
- Reset: drive RSTCTRL=1 with OPMODE=7'h35, CECTRL=1 -> after the edge all outputs are 0 and invalid_cnt=0.
- Legal load: OPMODEREG=1, OPMODE=7'b0110101 (M+C), CECTRL=1 -> next cycle x_sel=01, y_sel=01, z_sel=011, opmode_invalid=0. Then CECTRL=0 with a new OPMODE -> outputs hold.
- Illegal detection: OPMODE=7'b1110001, CECTRL=1 -> next cycle z_sel=111, x_sel=01, opmode_invalid=1, invalid_cnt=1.
- CARRYINSEL rule: MREG=0, CARRYINSEL=3'b110, CECTRL=1 -> opmode_invalid=1. Repeat with MREG=1 -> opmode_invalid=0.
- Saturation: 260 consecutive accepted illegal words -> invalid_cnt reads 8'hFF and stays there. A single RSTCTRL cycle returns it to 0.
- Pass-through mode: OPMODEREG=0, ALUMODEREG=0, toggle OPMODE each cycle -> selects follow within the same cycle. Illegal cycles are counted one cycle later.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared field positions and select/carry-in encodings for the DSP slice control word.
package dsp_ctrl_pkg;

    localparam int unsigned OPMODE_W = 7;
    localparam int unsigned ALUMODE_W = 4;
    localparam int unsigned CARRYINSEL_W = 3;

    localparam int unsigned X_LSB = 0;
    localparam int unsigned Y_LSB = 2;
    localparam int unsigned Z_LSB = 4;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_AB   = 2'b11;

    localparam logic [1:0] Y_ZERO = 2'b00;
    localparam logic [1:0] Y_M    = 2'b01;
    localparam logic [1:0] Y_ALL1 = 2'b10;
    localparam logic [1:0] Y_C    = 2'b11;

    localparam logic [2:0] Z_ZERO   = 3'b000;
    localparam logic [2:0] Z_PCIN   = 3'b001;
    localparam logic [2:0] Z_P      = 3'b010;
    localparam logic [2:0] Z_C      = 3'b011;
    localparam logic [2:0] Z_PMACC  = 3'b100;
    localparam logic [2:0] Z_PCIN17 = 3'b101;
    localparam logic [2:0] Z_P17    = 3'b110;
    localparam logic [2:0] Z_RSVD   = 3'b111;

    localparam logic [2:0] CIS_CARRYIN = 3'b000;
    localparam logic [2:0] CIS_PCIN_N  = 3'b001;
    localparam logic [2:0] CIS_CASCIN  = 3'b010;
    localparam logic [2:0] CIS_PCIN    = 3'b011;
    localparam logic [2:0] CIS_CASCOUT = 3'b100;
    localparam logic [2:0] CIS_P_N     = 3'b101;
    // Multiplier-sign carry: only meaningful when the M register is present.
    localparam logic [2:0] CIS_AB_XNOR = 3'b110;
    localparam logic [2:0] CIS_RSVD    = 3'b111;

endpackage

// File: rtl/ctrl_reg.sv
// Optional control register with clock enable and synchronous reset; bypassed when REG is 0.
module ctrl_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned REG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (REG != 0) begin : g_reg
        logic [WIDTH-1:0] q_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                q_r <= '0;
            end else if (ce) begin
                q_r <= d;
            end
        end

        assign q = q_r;
    end else begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign q = d;
    end

endmodule

// File: rtl/dsp_ctrl_decoder.sv
// DSP slice control-word front end: optional registers, X/Y/Z select split,
// legality flagging and a saturating illegal-word counter.
module dsp_ctrl_decoder
    import dsp_ctrl_pkg::*;
#(
    parameter int unsigned OPMODEREG  = 1,
    parameter int unsigned ALUMODEREG = 1,
    parameter int unsigned MREG       = 1
) (
    input  logic                    CLK,
    input  logic                    RSTCTRL,
    input  logic                    CECTRL,
    input  logic                    CEALUMODE,
    input  logic [OPMODE_W-1:0]     OPMODE,
    input  logic [ALUMODE_W-1:0]    ALUMODE,
    input  logic [CARRYINSEL_W-1:0] CARRYINSEL,
    output logic [1:0]              x_sel,
    output logic [1:0]              y_sel,
    output logic [2:0]              z_sel,
    output logic [ALUMODE_W-1:0]    alumode_q,
    output logic [CARRYINSEL_W-1:0] carryin_sel,
    output logic                    opmode_invalid,
    output logic [7:0]              invalid_cnt
);

    logic [OPMODE_W-1:0]     opmode_eff;
    logic [CARRYINSEL_W-1:0] carryin_eff;
    logic                    accept;
    logic                    d_illegal;
    logic [7:0]              cnt_q;
    logic [7:0]              cnt_d;

    function automatic logic is_illegal(input logic [OPMODE_W-1:0]     op,
                                        input logic [CARRYINSEL_W-1:0] cis);
        logic x_m;
        logic y_m;
        x_m = (op[X_LSB +: 2] == X_M);
        y_m = (op[Y_LSB +: 2] == Y_M);
        return (x_m ^ y_m) || (op[Z_LSB +: 3] == Z_RSVD) ||
               ((cis == CIS_AB_XNOR) && (MREG == 0)) || (cis == CIS_RSVD);
    endfunction

    ctrl_reg #(.WIDTH(OPMODE_W), .REG(OPMODEREG)) u_opmode_reg (
        .clk (CLK),
        .rst (RSTCTRL),
        .ce  (CECTRL),
        .d   (OPMODE),
        .q   (opmode_eff)
    );

    ctrl_reg #(.WIDTH(ALUMODE_W), .REG(ALUMODEREG)) u_alumode_reg (
        .clk (CLK),
        .rst (RSTCTRL),
        .ce  (CEALUMODE),
        .d   (ALUMODE),
        .q   (alumode_q)
    );

    ctrl_reg #(.WIDTH(CARRYINSEL_W), .REG(OPMODEREG)) u_carryinsel_reg (
        .clk (CLK),
        .rst (RSTCTRL),
        .ce  (CECTRL),
        .d   (CARRYINSEL),
        .q   (carryin_eff)
    );

    assign x_sel          = opmode_eff[X_LSB +: 2];
    assign y_sel          = opmode_eff[Y_LSB +: 2];
    assign z_sel          = opmode_eff[Z_LSB +: 3];
    assign carryin_sel    = carryin_eff;
    assign opmode_invalid = is_illegal(opmode_eff, carryin_eff);

    // Count on the D-side word so the count lands one cycle after acceptance in both modes.
    assign accept    = (OPMODEREG != 0) ? CECTRL : 1'b1;
    assign d_illegal = is_illegal(OPMODE, CARRYINSEL);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && d_illegal && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTCTRL) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign invalid_cnt = cnt_q;

endmodule

// File: tb/tb_dsp_ctrl_decoder.sv
// Randomised and directed checks of three decoder configurations against a spec-level model.
module tb_dsp_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       cea = 1'b0;
    logic [6:0] op = '0;
    logic [3:0] alu = '0;
    logic [2:0] cis = '0;

    logic [1:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [2:0] z_a, z_b, z_c, cis_a, cis_b, cis_c;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       inv_a, inv_b, inv_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    logic [22:0] obs_a, obs_b, obs_c;
    assign obs_a = {x_a, y_a, z_a, alu_a, cis_a, inv_a, cnt_a};
    assign obs_b = {x_b, y_b, z_b, alu_b, cis_b, inv_b, cnt_b};
    assign obs_c = {x_c, y_c, z_c, alu_c, cis_c, inv_c, cnt_c};

    int n_vec = 0;
    int n_err = 0;

    // Model state: registered word (shared by a/b) and one counter per instance.
    logic [6:0] m_op = '0;
    logic [3:0] m_alu = '0;
    logic [2:0] m_cis = '0;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;
    int         m_cnt_c = 0;

    always #5 clk = ~clk;

    dsp_ctrl_decoder #(.OPMODEREG(1), .ALUMODEREG(1), .MREG(1)) dut_a (
        .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .CEALUMODE(cea),
        .OPMODE(op), .ALUMODE(alu), .CARRYINSEL(cis),
        .x_sel(x_a), .y_sel(y_a), .z_sel(z_a), .alumode_q(alu_a),
        .carryin_sel(cis_a), .opmode_invalid(inv_a), .invalid_cnt(cnt_a)
    );

    dsp_ctrl_decoder #(.OPMODEREG(1), .ALUMODEREG(1), .MREG(0)) dut_b (
        .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .CEALUMODE(cea),
        .OPMODE(op), .ALUMODE(alu), .CARRYINSEL(cis),
        .x_sel(x_b), .y_sel(y_b), .z_sel(z_b), .alumode_q(alu_b),
        .carryin_sel(cis_b), .opmode_invalid(inv_b), .invalid_cnt(cnt_b)
    );

    dsp_ctrl_decoder #(.OPMODEREG(0), .ALUMODEREG(0), .MREG(1)) dut_c (
        .CLK(clk), .RSTCTRL(rst), .CECTRL(ce), .CEALUMODE(cea),
        .OPMODE(op), .ALUMODE(alu), .CARRYINSEL(cis),
        .x_sel(x_c), .y_sel(y_c), .z_sel(z_c), .alumode_q(alu_c),
        .carryin_sel(cis_c), .opmode_invalid(inv_c), .invalid_cnt(cnt_c)
    );

    function automatic bit illegal(input logic [6:0] o, input logic [2:0] s, input bit mreg);
        bit x_is_m = (o[1:0] == 2'b01);
        bit y_is_m = (o[3:2] == 2'b01);
        return (x_is_m != y_is_m) || (o[6:4] == 3'b111) || (s == 3'b110 && !mreg) ||
               (s == 3'b111);
    endfunction

    function automatic logic [22:0] exp_a();
        return {m_op[1:0], m_op[3:2], m_op[6:4], m_alu, m_cis,
                illegal(m_op, m_cis, 1'b1), 8'(m_cnt_a)};
    endfunction

    function automatic logic [22:0] exp_b();
        return {m_op[1:0], m_op[3:2], m_op[6:4], m_alu, m_cis,
                illegal(m_op, m_cis, 1'b0), 8'(m_cnt_b)};
    endfunction

    function automatic logic [22:0] exp_c();
        return {op[1:0], op[3:2], op[6:4], alu, cis, illegal(op, cis, 1'b1), 8'(m_cnt_c)};
    endfunction

    task automatic drive(input logic r, input logic c, input logic ca, input logic [6:0] o,
                         input logic [3:0] a, input logic [2:0] s);
        rst = r; ce = c; cea = ca; op = o; alu = a; cis = s;
    endtask

    // Advance the model by one edge using the currently driven inputs, then clock the DUTs.
    task automatic tick();
        if (rst) begin
            m_op = '0; m_alu = '0; m_cis = '0;
            m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
        end else begin
            if (ce) begin
                if (illegal(op, cis, 1'b1) && m_cnt_a < 255) m_cnt_a++;
                if (illegal(op, cis, 1'b0) && m_cnt_b < 255) m_cnt_b++;
                m_op = op; m_cis = cis;
            end
            if (cea) m_alu = alu;
            if (illegal(op, cis, 1'b1) && m_cnt_c < 255) m_cnt_c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 7'h35, 4'hA, 3'b111);
        tick();
        n_vec++;
        if (obs_a !== 23'd0) begin
            n_err++; $display("FAIL reset_a: got %h want %h", obs_a, 23'd0);
        end
        n_vec++;
        if (obs_b !== 23'd0) begin
            n_err++; $display("FAIL reset_b: got %h want %h", obs_b, 23'd0);
        end
        n_vec++;
        if (cnt_c !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt_c: got %h want %h", cnt_c, 8'd0);
        end
    endtask

    task automatic test_legal_load();
        drive(1'b0, 1'b1, 1'b0, 7'b0110101, 4'h0, 3'b000);
        tick();
        n_vec++;
        if ({x_a, y_a, z_a, inv_a} !== {2'b01, 2'b01, 3'b011, 1'b0}) begin
            n_err++;
            $display("FAIL legal_load: got %b want %b", {x_a, y_a, z_a, inv_a}, 8'b01010110);
        end
        drive(1'b0, 1'b0, 1'b0, 7'b1001110, 4'h5, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs_a !== exp_a() || {x_a, y_a, z_a} !== 7'b0101011) begin
                n_err++; $display("FAIL legal_hold: got %h want %h", obs_a, exp_a());
            end
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 3'b000);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'b1110001, 4'h0, 3'b000);
        tick();
        n_vec++;
        if ({z_a, x_a, inv_a, cnt_a} !== {3'b111, 2'b01, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL illegal_z: got %h want %h", {z_a, x_a, inv_a, cnt_a},
                     {3'b111, 2'b01, 1'b1, 8'd1});
        end
        n_vec++;
        if (obs_b !== exp_b()) begin
            n_err++; $display("FAIL illegal_b: got %h want %h", obs_b, exp_b());
        end
    endtask

    task automatic test_carryin();
        drive(1'b0, 1'b1, 1'b0, 7'b0000000, 4'h0, 3'b110);
        tick();
        n_vec++;
        if (inv_b !== 1'b1 || inv_a !== 1'b0) begin
            n_err++; $display("FAIL carryin_mreg: got a=%b b=%b want a=0 b=1", inv_a, inv_b);
        end
        n_vec++;
        if (obs_a !== exp_a() || obs_b !== exp_b()) begin
            n_err++;
            $display("FAIL carryin_full: got %h/%h want %h/%h", obs_a, obs_b, exp_a(), exp_b());
        end
    endtask

    task automatic test_ce_independent();
        drive(1'b0, 1'b1, 1'b1, 7'b0010101, 4'h3, 3'b001);
        tick();
        drive(1'b0, 1'b0, 1'b1, 7'b0100000, 4'hC, 3'b100);
        tick();
        n_vec++;
        if (alu_a !== 4'hC || z_a !== 3'b001 || obs_a !== exp_a()) begin
            n_err++; $display("FAIL ce_alu_only: got %h want %h", obs_a, exp_a());
        end
        drive(1'b0, 1'b1, 1'b0, 7'b0100000, 4'h6, 3'b100);
        tick();
        n_vec++;
        if (alu_a !== 4'hC || z_a !== 3'b010 || obs_a !== exp_a()) begin
            n_err++; $display("FAIL ce_op_only: got %h want %h", obs_a, exp_a());
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 3'b000);
        tick();
        drive(1'b0, 1'b1, 1'b0, 7'b1110001, 4'h0, 3'b000);
        for (int i = 0; i < 260; i++) begin
            tick();
            n_vec++;
            if (cnt_a !== 8'(m_cnt_a)) begin
                n_err++; $display("FAIL sat_step%0d: got %h want %h", i, cnt_a, 8'(m_cnt_a));
            end
        end
        n_vec++;
        if ({cnt_a, cnt_b, cnt_c} !== {8'hFF, 8'hFF, 8'hFF}) begin
            n_err++; $display("FAIL sat_final: got %h %h %h want ff", cnt_a, cnt_b, cnt_c);
        end
        drive(1'b1, 1'b0, 1'b0, 7'b1110001, 4'h0, 3'b000);
        tick();
        n_vec++;
        if ({cnt_a, cnt_b, cnt_c} !== 24'd0) begin
            n_err++; $display("FAIL sat_clear: got %h %h %h want 00", cnt_a, cnt_b, cnt_c);
        end
    endtask

    task automatic test_passthrough();
        logic [6:0] words [4] = '{7'b0110101, 7'b1110001, 7'b0000010, 7'b0010111};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, words[i % 4], 4'(i), 3'(i % 3));
            #1;
            n_vec++;
            if (obs_c !== exp_c()) begin
                n_err++; $display("FAIL pt_same_cycle%0d: got %h want %h", i, obs_c, exp_c());
            end
            tick();
            n_vec++;
            if (obs_c !== exp_c()) begin
                n_err++; $display("FAIL pt_count%0d: got %h want %h", i, obs_c, exp_c());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) == 0), 1'($urandom), 1'($urandom), 7'($urandom),
                  4'($urandom), 3'($urandom));
            #1;
            n_vec++;
            if (obs_c !== exp_c()) begin
                n_err++; $display("FAIL rnd_pt_comb%0d: got %h want %h", i, obs_c, exp_c());
            end
            tick();
            n_vec++;
            if (obs_a !== exp_a()) begin
                n_err++; $display("FAIL rnd_a%0d: got %h want %h", i, obs_a, exp_a());
            end
            n_vec++;
            if (obs_b !== exp_b()) begin
                n_err++; $display("FAIL rnd_b%0d: got %h want %h", i, obs_b, exp_b());
            end
            n_vec++;
            if (obs_c !== exp_c()) begin
                n_err++; $display("FAIL rnd_c%0d: got %h want %h", i, obs_c, exp_c());
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_load();
        test_illegal();
        test_carryin();
        test_ce_independent();
        test_saturation();
        test_passthrough();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
